// File: rtl/cal_carry_mc_if.sv
// Bus bundle for cal_carry_mc: raw delay-line taps and eye clear in,
// eye map, averaged spans and miss counters out.
interface cal_carry_mc_if #(
  parameter int unsigned TAPS = 100,
  parameter int unsigned CH   = 2,
  parameter int unsigned DW   = $clog2(TAPS)
);
  logic [CH*TAPS-1:0]     taps;
  logic                   clr;
  logic [CH*(TAPS-1)-1:0] eye;
  logic [CH*DW-1:0]       d;
  logic [CH-1:0]          d_valid;
  logic [CH*8-1:0]        miss;

  modport master (output taps, clr, input eye, d, d_valid, miss);
  modport slave  (input taps, clr, output eye, d, d_valid, miss);
endinterface

// File: rtl/cal_carry_mc.sv
// Multi-channel carry-chain calibrator: synchronises delay-line taps, keeps an
// eye map of transitions and round-robin scans each channel for its edge-1..3 span.
module cal_carry_mc #(
  parameter int unsigned TAPS     = 100,
  parameter int unsigned CH       = 2,
  parameter int unsigned HOLD     = 7,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic          c,
  input  logic          rn,
  cal_carry_mc_if.slave bus
);
  localparam int unsigned DW  = $clog2(TAPS);
  localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned AW  = DW + AVG_LOG2;
  localparam int unsigned SW  = AVG_LOG2 + 1;
  localparam int unsigned EW  = TAPS - 1;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  (* ASYNC_REG = "TRUE" *) logic [CH*TAPS-1:0] s1_q;
  (* ASYNC_REG = "TRUE" *) logic [CH*TAPS-1:0] s2_q;

  logic [CH*EW-1:0] eye_q, eye_d;
  logic [TAPS-1:0]  s2_ch [CH];

  logic [TAPS-1:0]  sr_q, sr_d;
  logic [DW-1:0]    k_q, k_d;
  logic [DW-1:0]    p1_q, p1_d;
  logic [DW-1:0]    p3_q, p3_d;
  logic [DW-1:0]    lk_q, lk_d;
  logic [1:0]       ne_q, ne_d;
  logic [CHW-1:0]   ch_q, ch_d;

  logic [AW-1:0]    acc_q  [CH];
  logic [AW-1:0]    acc_d  [CH];
  logic [SW-1:0]    scnt_q [CH];
  logic [SW-1:0]    scnt_d [CH];
  logic [7:0]       miss_q [CH];
  logic [7:0]       miss_d [CH];
  logic [DW-1:0]    d_q    [CH];
  logic [DW-1:0]    d_d    [CH];
  logic [CH-1:0]    dv_q, dv_d;

  logic             edge_ok;
  logic [AW-1:0]    sum;
  logic [SW-1:0]    scnt_inc;
  logic [CH*DW-1:0] d_flat;
  logic [CH*8-1:0]  miss_flat;

  // Two-stage synchroniser on every tap before any other use
  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.taps;
      s2_q <= s1_q;
    end
  end

  // Eye map: sticky OR of adjacent-tap differences, clear wins
  always_comb begin
    eye_d = eye_q;
    if (bus.clr) begin
      eye_d = '0;
    end else begin
      for (int n = 0; n < CH; n++) begin
        for (int k = 0; k < EW; k++) begin
          eye_d[n*EW+k] = eye_q[n*EW+k] | (s2_q[n*TAPS+k] ^ s2_q[n*TAPS+k+1]);
        end
      end
    end
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) eye_q <= '0;
    else     eye_q <= eye_d;
  end

  always_comb begin
    for (int n = 0; n < CH; n++) s2_ch[n] = s2_q[n*TAPS +: TAPS];
  end

  // Scan FSM: state register
  always_ff @(posedge c or negedge rn) begin
    if (!rn) state_q <= ST_LOAD;
    else     state_q <= state_d;
  end

  // Scan FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD: state_d = ST_SCAN;
      ST_SCAN: if (k_q == DW'(TAPS - 1)) state_d = ST_DONE;
      ST_DONE: state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase
  end

  // Scan FSM: datapath and output next values
  always_comb begin
    sr_d     = sr_q;
    k_d      = k_q;
    p1_d     = p1_q;
    p3_d     = p3_q;
    lk_d     = lk_q;
    ne_d     = ne_q;
    ch_d     = ch_q;
    acc_d    = acc_q;
    scnt_d   = scnt_q;
    miss_d   = miss_q;
    d_d      = d_q;
    dv_d     = '0;
    edge_ok  = 1'b0;
    sum      = '0;
    scnt_inc = '0;
    unique case (state_q)
      ST_LOAD: begin
        sr_d = s2_ch[ch_q];
        ne_d = '0;
        lk_d = '0;
        p1_d = '0;
        p3_d = '0;
        k_d  = DW'(1);
      end
      ST_SCAN: begin
        // sr[0]^sr[1] is the transition between taps k-1 and k
        edge_ok = (sr_q[0] ^ sr_q[1]) && (ne_q != 2'd3) &&
                  ((ne_q == 2'd0) || ((k_q - lk_q) > DW'(HOLD)));
        if (edge_ok) begin
          ne_d = ne_q + 2'd1;
          lk_d = k_q;
          if (ne_q == 2'd0) p1_d = k_q;
          if (ne_q == 2'd2) p3_d = k_q;
        end
        sr_d = {1'b0, sr_q[TAPS-1:1]};
        k_d  = k_q + DW'(1);
      end
      ST_DONE: begin
        if (ne_q == 2'd3) begin
          sum      = acc_q[ch_q] + AW'(p3_q - p1_q);
          scnt_inc = scnt_q[ch_q] + SW'(1);
          if (scnt_inc == SW'(1 << AVG_LOG2)) begin
            d_d[ch_q]    = DW'(sum >> AVG_LOG2);
            dv_d[ch_q]   = 1'b1;
            acc_d[ch_q]  = '0;
            scnt_d[ch_q] = '0;
          end else begin
            acc_d[ch_q]  = sum;
            scnt_d[ch_q] = scnt_inc;
          end
        end else if (miss_q[ch_q] != 8'hFF) begin
          miss_d[ch_q] = miss_q[ch_q] + 8'd1;
        end
        ch_d = (ch_q == CHW'(CH - 1)) ? '0 : ch_q + CHW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge c or negedge rn) begin
    if (!rn) begin
      sr_q   <= '0;
      k_q    <= '0;
      p1_q   <= '0;
      p3_q   <= '0;
      lk_q   <= '0;
      ne_q   <= '0;
      ch_q   <= '0;
      acc_q  <= '{default: '0};
      scnt_q <= '{default: '0};
      miss_q <= '{default: '0};
      d_q    <= '{default: '0};
      dv_q   <= '0;
    end else begin
      sr_q   <= sr_d;
      k_q    <= k_d;
      p1_q   <= p1_d;
      p3_q   <= p3_d;
      lk_q   <= lk_d;
      ne_q   <= ne_d;
      ch_q   <= ch_d;
      acc_q  <= acc_d;
      scnt_q <= scnt_d;
      miss_q <= miss_d;
      d_q    <= d_d;
      dv_q   <= dv_d;
    end
  end

  // Flatten per-channel registers onto the bus
  always_comb begin
    d_flat    = '0;
    miss_flat = '0;
    for (int n = 0; n < CH; n++) begin
      d_flat[n*DW +: DW]  = d_q[n];
      miss_flat[n*8 +: 8] = miss_q[n];
    end
  end

  assign bus.eye     = eye_q;
  assign bus.d       = d_flat;
  assign bus.d_valid = dv_q;
  assign bus.miss    = miss_flat;

endmodule

// File: tb/tb_cal_carry_mc.sv
// Randomised bench for cal_carry_mc against a scan-slot level reference model.
module tb_cal_carry_mc;
  localparam int unsigned TAPS     = 100;
  localparam int unsigned CH       = 2;
  localparam int unsigned HOLD     = 7;
  localparam int unsigned AVG_LOG2 = 2;
  localparam int unsigned DW       = $clog2(TAPS);
  localparam int unsigned EW       = TAPS - 1;
  localparam int          PER      = TAPS + 1;

  logic c;
  logic rn;

  cal_carry_mc_if #(.TAPS(TAPS), .CH(CH)) bus ();

  cal_carry_mc #(.TAPS(TAPS), .CH(CH), .HOLD(HOLD), .AVG_LOG2(AVG_LOG2)) dut (
    .c   (c),
    .rn  (rn),
    .bus (bus)
  );

  initial begin
    c = 1'b0;
    forever #5 c = ~c;
  end

  int n_chk = 0;
  int n_err = 0;

  int                 e;
  int                 mode;
  logic [CH*TAPS-1:0] taps_drv;
  logic               clr_drv;
  logic [CH*TAPS-1:0] pipe1, pipe2;
  logic [CH*EW-1:0]   eye_m;
  logic [TAPS-1:0]    act_pat, pend_pat;
  logic [CH-1:0]      dv_m;
  int                 acc_m  [CH];
  int                 cnt_m  [CH];
  int                 miss_m [CH];
  int                 d_m    [CH];
  logic [TAPS-1:0]    q0[$];
  logic [TAPS-1:0]    q1[$];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pattern with transitions (bit k-1 != bit k) at the listed k; -1 = unused
  function automatic logic [TAPS-1:0] mk_pat(input int a, input int b, input int x, input int y);
    logic [TAPS-1:0] p;
    logic lvl;
    lvl = 1'($urandom_range(0, 1));
    for (int k = 0; k < int'(TAPS); k++) begin
      if (k == a || k == b || k == x || k == y) lvl = ~lvl;
      p[k] = lvl;
    end
    return p;
  endfunction

  function automatic logic [TAPS-1:0] rnd_pat(input bit few);
    logic [TAPS-1:0] p;
    logic lvl;
    int f1, f2;
    f1  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, TAPS - 1)) : -1;
    f2  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, TAPS - 1)) : -1;
    lvl = 1'($urandom_range(0, 1));
    for (int k = 0; k < int'(TAPS); k++) begin
      if (k > 0 && (few ? (k == f1 || k == f2) : ($urandom_range(0, 15) == 0))) lvl = ~lvl;
      p[k] = lvl;
    end
    return p;
  endfunction

  // Span edge3-edge1 after holdoff filtering, or -1 for fewer than 3 edges
  function automatic int span_of(input logic [TAPS-1:0] p);
    int acc_k[$];
    for (int k = 1; k < int'(TAPS); k++) begin
      if (p[k] != p[k-1]) begin
        if (acc_k.size() == 0) acc_k.push_back(k);
        else if (acc_k.size() < 3 && (k - acc_k[$]) > int'(HOLD)) acc_k.push_back(k);
      end
    end
    return (acc_k.size() == 3) ? acc_k[2] - acc_k[0] : -1;
  endfunction

  function automatic logic [CH*EW-1:0] trans_of(input logic [CH*TAPS-1:0] t);
    logic [CH*EW-1:0] r;
    for (int n = 0; n < int'(CH); n++)
      for (int k = 0; k < int'(EW); k++)
        r[n*EW+k] = t[n*TAPS+k] ^ t[n*TAPS+k+1];
    return r;
  endfunction

  function automatic logic [CH*DW-1:0] pack_d();
    logic [CH*DW-1:0] r;
    for (int n = 0; n < int'(CH); n++) r[n*DW +: DW] = DW'(d_m[n]);
    return r;
  endfunction

  function automatic logic [CH*8-1:0] pack_miss();
    logic [CH*8-1:0] r;
    for (int n = 0; n < int'(CH); n++) r[n*8 +: 8] = 8'(miss_m[n]);
    return r;
  endfunction

  task automatic pick_pat(input int n, output logic [TAPS-1:0] p);
    if (n == 0 && q0.size() > 0)      p = q0.pop_front();
    else if (n == 1 && q1.size() > 0) p = q1.pop_front();
    else                              p = rnd_pat(mode == 1 && n == 1);
  endtask

  // Advance one clock, update the model for that edge, compare, drive next inputs
  task automatic tick();
    int j, n, sp;
    @(posedge c);
    @(negedge c);
    e++;
    eye_m = clr_drv ? '0 : (eye_m | trans_of(pipe2));
    pipe2 = pipe1;
    pipe1 = taps_drv;
    dv_m  = '0;
    if (e % PER == 0) begin
      j  = e / PER - 1;
      n  = j % int'(CH);
      sp = span_of(act_pat);
      if (sp >= 0) begin
        acc_m[n] += sp;
        cnt_m[n]++;
        if (cnt_m[n] == (1 << AVG_LOG2)) begin
          d_m[n]   = acc_m[n] >> AVG_LOG2;
          dv_m[n]  = 1'b1;
          acc_m[n] = 0;
          cnt_m[n] = 0;
        end
      end else if (miss_m[n] < 255) begin
        miss_m[n]++;
      end
    end
    if (e % PER == 1) begin
      j       = (e - 1) / PER;
      act_pat = pend_pat;
      n       = (j + 1) % int'(CH);
      pick_pat(n, pend_pat);
      taps_drv[n*TAPS +: TAPS] = pend_pat;
      bus.taps = taps_drv;
    end
    chk("d_valid", 256'(bus.d_valid), 256'(dv_m));
    chk("d",       256'(bus.d),       256'(pack_d()));
    chk("miss",    256'(bus.miss),    256'(pack_miss()));
    chk("eye",     256'(bus.eye),     256'(eye_m));
    clr_drv = ($urandom_range(0, 49) == 0);
    bus.clr = clr_drv;
  endtask

  task automatic do_reset();
    #2 rn = 1'b0;
    #1;
    chk("rst_d_valid", 256'(bus.d_valid), 256'(0));
    chk("rst_d",       256'(bus.d),       256'(0));
    chk("rst_miss",    256'(bus.miss),    256'(0));
    chk("rst_eye",     256'(bus.eye),     256'(0));
    repeat (3) @(negedge c);
    rn       = 1'b1;
    e        = 0;
    eye_m    = '0;
    pipe1    = '0;
    pipe2    = '0;
    act_pat  = '0;
    pend_pat = '0;
    for (int n = 0; n < int'(CH); n++) begin
      acc_m[n]  = 0;
      cnt_m[n]  = 0;
      miss_m[n] = 0;
      d_m[n]    = 0;
    end
  endtask

  initial begin
    rn       = 1'b1;
    mode     = 0;
    clr_drv  = 1'b0;
    bus.clr  = 1'b0;
    taps_drv = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    bus.taps = taps_drv;

    repeat (4) q0.push_back(mk_pat(10, 40, 70, -1));
    repeat (4) q0.push_back(mk_pat(10, 12, 40, 70));
    repeat (4) q0.push_back(mk_pat(10, 17, 40, 70));
    repeat (2) begin
      q0.push_back(mk_pat(10, 40, 70, -1));
      q0.push_back(mk_pat(10, 40, 71, -1));
    end
    repeat (4) q0.push_back(mk_pat(10, 18, 40, -1));
    repeat (2) q0.push_back(mk_pat(50, -1, -1, -1));
    repeat (4) q0.push_back(mk_pat(10, 40, 70, 85));
    repeat (20) q1.push_back(mk_pat(20, 50, -1, -1));

    do_reset();
    repeat (60 * PER) tick();
    repeat (10 * PER) tick();

    // Reset in the middle of a ch1 scan
    for (int i = 0; i < 2 * int'(CH) * PER; i++) begin
      if (((e - 1) / PER) % int'(CH) == 1 && (e - 1) % PER == 40) break;
      tick();
    end
    do_reset();

    mode = 1;
    repeat (530 * PER) tick();
    chk("miss_ch1_sat", 256'(bus.miss[15:8]), 256'(255));
    mode = 0;
    repeat (20 * PER) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cal_carry_mc.md
CAL_CARRY_MC -- requirements
Module: cal_carry_mc

Interface
REQ-001 Parameter TAPS, default 100: taps per channel delay line, range 16..512.
REQ-002 Parameter CH, default 2: number of channels, range 1..8.
REQ-003 Parameter HOLD, default 7: edge holdoff in taps, range 1..15.
REQ-004 Parameter AVG_LOG2, default 2: scans averaged per result, range 0..6.
REQ-005 Derived DW = clog2(TAPS): width of tap positions and results.
REQ-006 c  input  1  sole clock; all logic rising-edge.
REQ-007 rn  input  1  reset; asynchronous, active-low.
REQ-008 taps  input  CH*TAPS  raw delay-line samples; channel n at [n*TAPS +: TAPS]; bit 0 is the earliest tap.
REQ-009 clr  input  1  synchronous clear of all eye bits.
REQ-010 eye  output  CH*(TAPS-1)  accumulated adjacent-tap transitions; channel n at [n*(TAPS-1) +: TAPS-1].
REQ-011 d  output  CH*DW  averaged edge-1-to-edge-3 span per channel, in taps.
REQ-012 d_valid  output  CH  one-cycle pulse per channel when its d updates.
REQ-013 miss  output  CH*8  per-channel count of scans finding fewer than 3 edges; saturates at 255.

Function
REQ-014 Each taps channel SHALL pass through two register stages (s1, s2) marked ASYNC_REG before any other use.
REQ-015 eye bit k of channel n SHALL be set in any cycle where s2 bits k and k+1 of channel n differ; bits stay set until clr.
REQ-016 clr SHALL zero all eye bits on the next edge, taking priority over a same-cycle set.
REQ-017 A single scan FSM SHALL serve channels round-robin 0..CH-1 with states LOAD, SCAN, DONE.
REQ-018 LOAD (1 cycle): copy current channel's s2 into shift register sr; clear edge count and holdoff; set index k=1; go to SCAN.
REQ-019 SCAN (TAPS-1 cycles, k=1..TAPS-1): sr[0]^sr[1] is the transition between taps k-1 and k; shift sr right one bit per cycle; after k=TAPS-1 go to DONE.
REQ-020 A transition SHALL count as an edge only when the holdoff has expired, i.e. no accepted edge earlier in this scan or k minus the last accepted k exceeds HOLD.
REQ-021 Edge count SHALL saturate at 3; record k of edge 1 as p1 and of edge 3 as p3; edges after the third are ignored.
REQ-022 DONE (1 cycle): with 3 edges, add p3-p1 into the channel accumulator (DW+AVG_LOG2 bits) and increment its scan count; otherwise increment miss (saturating) and leave accumulator and count unchanged; then advance channel (CH-1 wraps to 0) and go to LOAD.
REQ-023 When a channel's scan count reaches 2^AVG_LOG2, in that DONE cycle: d <= accumulator_with_this_add >> AVG_LOG2 (truncate), d_valid pulses for the following cycle only, accumulator and count clear.
REQ-024 One channel's scan occupies TAPS+1 cycles; a full rotation takes CH*(TAPS+1) cycles.
REQ-025 d holds its last value between updates; d_valid for different channels never pulse in the same cycle.

Reset
REQ-026 rn low SHALL asynchronously clear s1, s2, sr, eye, d, d_valid, miss, accumulators, scan counts and edge state, and force FSM to LOAD with channel 0.
REQ-027 On rn release the first LOAD occurs on the first rising edge of c with rn high; reset mid-scan discards that scan entirely.

Verification
REQ-028 TAPS=100, CH=2, AVG_LOG2=2, HOLD=7; ch0 static pattern with transitions at k=10,40,70 -> after the 4th ch0 DONE, d[ch0]=60 with one d_valid[0] pulse; ch1 unaffected.
REQ-029 ch0 transitions at k=10,12,40,70 -> k=12 rejected by holdoff; d[ch0]=60; transitions at k=10,18 -> 18 accepted (18-10=8>7).
REQ-030 ch1 transitions only at k=20,50 -> no d_valid[1]; miss[ch1] increments once per ch1 scan and holds at 255 after 255 scans.
REQ-031 Alternating ch0 spans 60,61,60,61 over 4 scans -> d[ch0]=60 (242>>2, truncation).
REQ-032 Single transition at k=50 on ch0 -> eye bit 49 of ch0 set within 3 cycles; clr asserted with transition still present -> eye bit reads 0 after that edge, set again the next cycle.
REQ-033 rn pulsed low during ch1 SCAN -> all outputs 0 asynchronously; after release next DONE is for ch0 at cycle TAPS+1; prior partial accumulations absent from next d.
